// File: rtl/mem_access_unit.sv
// Load/store engine between the CPU memory stage and a word-wide memory port.
// Sub-word stores run as read-modify-write pairs; loads return extended lane data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_write,
    input  logic [31:0] mem_dout,
    input  logic        mem_busy,
    output logic [2:0]  state_dbg
);
    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // resp_valid is a one-cycle pulse with no back-pressure; a memory phase
    // completes on a rising edge with mem_busy low.
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);

    state_t      state;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [15:0] tcnt;

    logic        bad_req;
    logic        in_phase;
    logic        timeout_hit;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign bad_req = (req_size == 2'b10)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b11 && req_addr[1:0] != 2'b00);
    assign in_phase = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, tcnt} + 17'd1) == TO_LIMIT);

    // Lane select and merge, little-endian: byte k at [8k+7:8k], half h at [16h+15:16h].
    always_comb begin
        rd_byte   = 8'(mem_dout >> {addr_q[1:0], 3'b000});
        rd_half   = 16'(mem_dout >> {addr_q[1], 4'b0000});
        lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << {addr_q[1:0], 3'b000})
                                      : (32'h0000_FFFF << {addr_q[1], 4'b0000});
        lane_data = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
        merged    = (mem_dout & ~lane_mask) | (lane_data & lane_mask);
        case (size_q)
            2'b00:   load_data = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            2'b01:   load_data = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: load_data = mem_dout;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            resp_rdata <= '0;
            resp_err   <= 2'b00;
            tcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= 2'b00;
                        tcnt       <= '0;
                        if (bad_req) begin
                            state    <= RESP;
                            resp_err <= 2'b01;
                        end else if (!req_write) begin
                            state <= RD;
                        end else if (req_size == 2'b11) begin
                            state <= WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                RD, WR, RMW_RD, RMW_WR: begin
                    if (mem_busy) begin
                        tcnt <= tcnt + 16'd1;
                        // An abort in RMW_RD never reaches the write phase.
                        if (timeout_hit) begin
                            state    <= RESP;
                            resp_err <= 2'b10;
                        end
                    end else if (state == RD) begin
                        resp_rdata <= load_data;
                        state      <= RESP;
                    end else if (state == RMW_RD) begin
                        merged_q <= merged;
                        tcnt     <= '0;
                        state    <= RMW_WR;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from state so a reset drops the strobe in the same cycle.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_write  = (state == WR) || (state == RMW_WR);
    assign mem_addr   = in_phase ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_din    = (state == WR) ? wdata_q : ((state == RMW_WR) ? merged_q : 32'h0);
    assign state_dbg  = state;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store engine that sits between the CPU memory stage and the data port of the unified memory. It accepts one byte, halfword or word load/store request at a time and drives a word-wide memory interface with address, write data and write strobe, waiting on busy. It builds byte/halfword stores as read-modify-write pairs and returns aligned, sign- or zero-extended load data. It also flags misaligned, illegal-size and timed-out accesses.

## Interface

- TIMEOUT, 255: max consecutive busy cycles per memory phase before abort; 0 disables; ≤ 65535.
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 11 word, 10 illegal.
- req_unsigned  input  1  zero-extend loads (ignored for stores and words).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  2  00 ok, 01 misaligned/illegal size, 10 timeout.
- mem_addr  output  32  word address to memory, bits [1:0] = 00.
- mem_din  output  32  write data to memory.
- mem_write  output  1  write strobe.
- mem_dout  input  32  read data from memory, combinational from mem_addr.
- mem_busy  input  1  memory not ready; current phase holds while high.

## Operation

- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. A request is accepted on a rising edge with req_valid=1. The unit latches write, size, unsigned, addr and wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=10: go to RESP with err=01. No memory phase is issued.
  - Otherwise: load → RD, sw → WR, sb/sh → RMW_RD.
- RD: mem_addr={addr[31:2],2'b00}, mem_write=0. When mem_busy=0, the unit extracts the lane, registers resp_rdata and goes to RESP.
- WR: mem_write=1, mem_din=wdata. When mem_busy=0, go to RESP.
- RMW_RD: read as in RD. When mem_busy=0, the unit registers the merged word (old word with the target lane replaced by wdata[7:0] or wdata[15:0]) and goes to RMW_WR.
- RMW_WR: mem_write=1, mem_din=merged word. When mem_busy=0, go to RESP.
- RESP: resp_valid=1 and req_ready=0 for exactly one cycle, then IDLE.
- Lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword h = addr[1] occupies bits [16h+15:16h].
  - Sign extension copies the lane MSB unless unsigned=1.
- Timeout: a 16-bit counter clears on every phase entry and increments each cycle in which mem_busy=1. When it reaches TIMEOUT (TIMEOUT≠0), the unit goes to RESP with err=10 and resp_rdata=0.
  - A timeout in RMW_RD skips the write, so memory is unchanged.
- Outside RD/WR/RMW_*: mem_addr=0, mem_din=0, mem_write=0.

## Timing

- Reset (asynchronous, immediate): state IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00, mem_addr=0, mem_din=0, mem_write=0, timeout counter=0.
- mem_write decodes combinationally from state, so a reset in WR or RMW_WR drops the strobe in the same cycle. No partial response is produced.
- Latency from the accept edge to the resp_valid cycle, with busy=0:
  - Load or sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
  - Each busy cycle adds 1.
- Request inputs are sampled only at accept. Changes after accept are ignored.
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP. Throughput is at most 1 request per 3 cycles.
- Memory writes commit on the rising edge ending a WR/RMW_WR cycle with mem_busy=0.

## Test plan

- Load widths:
  - Stimulus: memory word 0x1000_0000 = 0x8899_AABB.
  - lb @0x1000_0001 → rdata 0xFFFF_FFAA.
  - lbu @0x1000_0001 → rdata 0x0000_00AA.
  - lh @0x1000_0002 → rdata 0xFFFF_8899.
  - lw @0x1000_0000 → rdata 0x8899_AABB, err 00, resp 2 cycles after accept.
- RMW stores:
  - Stimulus: word = 0x1122_3344; sb 0xEE @addr+2, then sh 0xBEEF @addr+0.
  - Required: word = 0x11EE_BEEF after both stores.
  - Each store issues exactly one read and one write; resp 3 cycles after accept.
- Misaligned and illegal accesses:
  - lw @0x1000_0002, sh @0x1000_0001 and size=10 → err 01 one cycle after accept.
  - Required: mem_write never asserted, memory unchanged.
- Busy stall:
  - Stimulus: mem_busy high for 5 cycles during sw 0xDEAD_BEEF.
  - Required: mem_write/mem_addr held stable; resp 7 cycles after accept; memory updated once.
- Timeout:
  - Stimulus: TIMEOUT=4, mem_busy stuck high during an sb.
  - Required: err 10 after 4 busy cycles, no write phase, memory unchanged, req_ready=1 next cycle.
- Reset mid-operation:
  - Stimulus: reset_n low in RMW_WR.
  - Required: mem_write drops immediately, no resp_valid, all outputs at reset values. The next lw completes normally.
